// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front end: synchroniser, mid-bit sampler and one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive and check an even-parity bit after bit 7.
module uart_rx_frontend #(
  parameter int unsigned CLKS_PER_BIT = 416,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NumBits = 9;
`else
  localparam int unsigned NumBits = 8;
`endif

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [NumBits-1:0]   shift_q, shift_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_s, cnt_zero, stop_good, stop_bad, deliver, ovr_set;

  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = CntW'(CLKS_PER_BIT / 2 - 1);
        end
      end
      StStart: begin
        if (cnt_zero) begin
          if (!rx_s) begin
            state_d = StData;
            cnt_d   = CntW'(CLKS_PER_BIT - 1);
            idx_d   = 4'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (cnt_zero) begin
          // LSB arrives first, so shift in from the top
          shift_d = {rx_s, shift_q[NumBits-1:1]};
          cnt_d   = CntW'(CLKS_PER_BIT - 1);
          if (idx_q == 4'(NumBits - 1)) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStop: begin
        if (cnt_zero) begin
          if (rx_s) begin
            stop_good = 1'b1;
            state_d   = StIdle;
          end else begin
            stop_bad = 1'b1;
            state_d  = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWaitHigh: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data plus parity bit must XOR to zero
  assign deliver = stop_good & ~(^shift_q);
  assign ferr_d  = stop_bad | (stop_good & (^shift_q));
`else
  assign deliver = stop_good;
  assign ferr_d  = stop_bad;
`endif

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovr_set    = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q[7:0];
        rx_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    overrun_d = ovr_set | (overrun_q & ~clr_err);
  end

  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      shift_q    <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = ferr_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: frame-level event model plus directed literal checks.
module tb_uart_rx_frontend;

  localparam int unsigned CPB  = 16;
  localparam int unsigned SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NB  = 9;
  localparam int unsigned LAT = 169;
`else
  localparam int unsigned NB  = 8;
  localparam int unsigned LAT = 153;
`endif
  // Offset from the cycle the start bit is driven to the stop-sample cycle
  localparam int unsigned SOFF = SYNC + CPB / 2 + (NB + 1) * CPB;
  localparam int unsigned FLEN = (NB + 2) * CPB;

  logic       clk_48mhz = 1'b0;
  logic       reset     = 1'b0;
  logic       rx_in     = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready  = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       clr_err   = 1'b0;
  logic       busy;

  uart_rx_frontend #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_48mhz(clk_48mhz),
    .reset    (reset),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .clr_err  (clr_err),
    .busy     (busy)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int unsigned cyc = 0;
  always @(posedge clk_48mhz) cyc <= cyc + 1;

  // Model: one event per frame, applied at its stop-sample cycle
  typedef struct {
    int unsigned at;
    bit          good;
    logic [7:0]  data;
  } ev_t;
  ev_t evq[$];

  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ovr   = 1'b0;
  logic       m_ferr  = 1'b0;
  bit         ovr_set;

  always @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_ovr   <= 1'b0;
      m_ferr  <= 1'b0;
      evq.delete();
    end else begin
      ovr_set = 1'b0;
      m_ferr <= 1'b0;
      if (m_valid && rx_ready) m_valid <= 1'b0;
      if (evq.size() != 0 && evq[0].at == cyc) begin
        if (evq[0].good) begin
          if (!m_valid || rx_ready) begin
            m_valid <= 1'b1;
            m_data  <= evq[0].data;
          end else begin
            ovr_set = 1'b1;
          end
        end else begin
          m_ferr <= 1'b1;
        end
        void'(evq.pop_front());
      end
      m_ovr <= ovr_set | (m_ovr & ~clr_err);
    end
  end

  int unsigned rise_cyc = 0;
  int          ferr_cnt = 0;
  logic        prev_valid = 1'b0;

  always @(negedge clk_48mhz) begin
    if (reset) begin
      chk("cmp_valid", {31'd0, rx_valid}, {31'd0, m_valid});
      chk("cmp_data", {24'd0, rx_data}, {24'd0, m_data});
      chk("cmp_overrun", {31'd0, overrun}, {31'd0, m_ovr});
      chk("cmp_frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (frame_err) ferr_cnt++;
    end
    prev_valid = rx_valid;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask

  int unsigned last_t;

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                            input int abort_bit);
    ev_t           e;
    logic [8:0]    fr;
    logic [NB-1:0] bits;
    fr     = {par_bit, d};
    bits   = fr[NB-1:0];
    last_t = cyc + SYNC;
    e.at   = cyc + SOFF;
    e.data = d;
    e.good = stop_bit && (^bits == 1'b0 || NB == 8);
    evq.push_back(e);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < int'(NB); i++) begin
      rx_in = bits[i];
      if (i == abort_bit) begin
        tick(CPB / 2);
        return;
      end
      tick(CPB);
    end
    rx_in = stop_bit;
    tick(CPB);
  endtask

  task automatic take();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

  int base_ferr;

  initial begin
    tick(3);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    reset = 1'b1;
    tick(1000);
    chk("idle_valid", {31'd0, rx_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_overrun", {31'd0, overrun}, 32'd0);
    chk("idle_ferr_cnt", ferr_cnt, 0);

    // 0xA5, exact latency
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    chk("a5_latency", rise_cyc - last_t, LAT);
    chk("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
    chk("a5_valid", {31'd0, rx_valid}, 32'd1);
    take();
    chk("a5_consumed", {31'd0, rx_valid}, 32'd0);

    // Back-to-back with no consumer: second byte overruns
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    send_frame(8'h81, 1'b0, 1'b1, -1);
    chk("ovr_data", {24'd0, rx_data}, 32'h0000_003C);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);
    take();
    chk("ovr_emptied", {31'd0, rx_valid}, 32'd0);

    // Back-to-back with a consume in the second byte's delivery cycle
    fork
      begin
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        send_frame(8'h81, 1'b0, 1'b1, -1);
      end
      begin
        tick(FLEN + SOFF);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    chk("swap_data", {24'd0, rx_data}, 32'h0000_0081);
    chk("swap_valid", {31'd0, rx_valid}, 32'd1);
    chk("swap_overrun", {31'd0, overrun}, 32'd0);
    take();

    // Short low glitch is rejected
    rx_in = 1'b0;
    tick(5);
    rx_in = 1'b1;
    chk("glitch_busy_mid", {31'd0, busy}, 32'd1);
    tick(20);
    chk("glitch_busy_end", {31'd0, busy}, 32'd0);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_ferr_cnt", ferr_cnt, 0);

    // Stop bit low followed by a long break
    base_ferr = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0, -1);
    tick(100);
    chk("break_busy", {31'd0, busy}, 32'd1);
    rx_in = 1'b1;
    tick(2 * CPB);
    chk("break_ferr_once", ferr_cnt - base_ferr, 1);
    chk("break_valid", {31'd0, rx_valid}, 32'd0);
    chk("break_busy_end", {31'd0, busy}, 32'd0);
    send_frame(8'h12, 1'b0, 1'b1, -1);
    chk("after_break_data", {24'd0, rx_data}, 32'h0000_0012);
    chk("after_break_valid", {31'd0, rx_valid}, 32'd1);

    // Reset in the middle of bit 4 abandons the frame
    send_frame(8'h6B, 1'b1, 1'b1, 4);
    chk("midframe_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    rx_in = 1'b1;
    #1;
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    tick(2);
    reset = 1'b1;
    tick(CPB);
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    chk("f0_data", {24'd0, rx_data}, 32'h0000_00F0);
    chk("f0_valid", {31'd0, rx_valid}, 32'd1);
    take();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, -1);
    chk("par_ok_data", {24'd0, rx_data}, 32'h0000_0007);
    chk("par_ok_valid", {31'd0, rx_valid}, 32'd1);
    take();
    base_ferr = ferr_cnt;
    send_frame(8'h07, 1'b0, 1'b1, -1);
    chk("par_bad_ferr", ferr_cnt - base_ferr, 1);
    chk("par_bad_valid", {31'd0, rx_valid}, 32'd0);
    chk("par_bad_busy", {31'd0, busy}, 32'd0);
`endif

    tick(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
